// File: rtl/juego_pkg.sv
// Shared types and constants for the board-game turn controller.
package juego_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCAL,
    WAIT_REMOTE,
    ISSUE,
    DONE
  } turno_state_t;

  localparam logic [2:0] FRAME_HDR      = 3'b101;
  localparam logic       JUGADOR_LOCAL  = 1'b0;
  localparam logic       JUGADOR_REMOTO = 1'b1;

  function automatic logic jugada_legal(input logic [2:0] j, input int max_j);
    return int'({29'b0, j}) <= max_j;
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// SPI slave receiver oversampled in the clk domain: synchronisers, sck edge
// detect and an MSB-first 8-bit shifter emitting a one-cycle frame strobe.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss_n,
  output logic       frame_valid,
  output logic [7:0] frame_byte
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic                   sck_prev;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   ss_s;
  logic                   sck_rise;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift_q;

  // NOTE: the synchronisers and edge-detect flop carry no reset so they keep
  // tracking the pins through rst; otherwise a high sck at release looks like an edge.
  always_ff @(posedge clk) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_n};
    sck_prev  <= sck_s;
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign ss_s     = ss_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      frame_valid <= 1'b0;
      frame_byte  <= '0;
    end else begin
      frame_valid <= 1'b0;
      if (ss_s) begin
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shift_q <= {shift_q[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          frame_valid <= 1'b1;
          frame_byte  <= {shift_q, mosi_s};
        end
      end
    end
  end

endmodule

// File: rtl/turno_jugada_ctrl.sv
// Turn controller: admits the local (button) or remote (SPI) move whose turn it
// is, hands it to game logic over valid/ready, and passes the turn on timeout.
module turno_jugada_ctrl
  import juego_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int TURN_TIMEOUT_S = 30,
  parameter int MAX_JUGADA     = 6,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       mosi,
  input  logic       ss_n,
  input  logic       btn_valid,
  input  logic [2:0] btn_jugada,
  input  logic       move_ready,
  input  logic       game_over,
  output logic       move_valid,
  output logic [2:0] jugada_out,
  output logic       jugador_out,
  output logic       turno,
  output logic       timeout,
  output logic       ack_out,
  output logic       err_frame
);

  localparam longint        TURN_CYCLES = longint'(CLK_HZ) * longint'(TURN_TIMEOUT_S);
  localparam int            TW          = $clog2(TURN_CYCLES);
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TURN_CYCLES - 1);

  turno_state_t  state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    jugada_q, jugada_d;
  logic          jugador_q, jugador_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          timeout_q, timeout_d;

  logic          frame_valid;
  logic [7:0]    frame_byte;
  logic          frame_good;
  logic          btn_good;
  logic          timer_done;
  logic          unused_frame_bits;

  spi_frame_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
    .clk         (clk),
    .rst         (rst),
    .sck         (sck),
    .mosi        (mosi),
    .ss_n        (ss_n),
    .frame_valid (frame_valid),
    .frame_byte  (frame_byte)
  );

  assign unused_frame_bits = ^frame_byte[4:3];
  assign frame_good = (frame_byte[7:5] == FRAME_HDR) && jugada_legal(frame_byte[2:0], MAX_JUGADA);
  assign btn_good   = btn_valid && jugada_legal(btn_jugada, MAX_JUGADA);
  assign timer_done = (timer_q == TIMER_LAST);

  // NOTE: every next-state signal is defaulted before the case so no path leaves
  // one unassigned; the timer default of zero also gives the clear-on-entry behaviour.
  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    jugada_d  = jugada_q;
    jugador_d = jugador_q;
    ack_d     = ack_q;
    err_d     = err_q;
    timeout_d = 1'b0;

    if (frame_valid && state_q != WAIT_REMOTE) err_d = 1'b1;

    case (state_q)
      WAIT_LOCAL: begin
        if (game_over) begin
          state_d = DONE;
        end else if (btn_good) begin
          jugada_d  = btn_jugada;
          jugador_d = JUGADOR_LOCAL;
          state_d   = ISSUE;
        end else if (timer_done) begin
          timeout_d = 1'b1;
          state_d   = WAIT_REMOTE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_REMOTE: begin
        if (frame_valid && !frame_good) err_d = 1'b1;
        if (game_over) begin
          state_d = DONE;
        end else if (frame_valid && frame_good) begin
          jugada_d  = frame_byte[2:0];
          jugador_d = JUGADOR_REMOTO;
          ack_d     = ~ack_q;
          state_d   = ISSUE;
        end else if (timer_done) begin
          timeout_d = 1'b1;
          state_d   = WAIT_LOCAL;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ISSUE: begin
        if (move_ready) begin
          if (game_over)                        state_d = DONE;
          else if (jugador_q == JUGADOR_REMOTO) state_d = WAIT_LOCAL;
          else                                  state_d = WAIT_REMOTE;
        end
      end
      DONE: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCAL;
      timer_q   <= '0;
      jugada_q  <= '0;
      jugador_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      jugada_q  <= jugada_d;
      jugador_q <= jugador_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign move_valid  = (state_q == ISSUE);
  assign jugada_out  = jugada_q;
  assign jugador_out = jugador_q;
  assign turno       = (state_q == WAIT_REMOTE) || (state_q == ISSUE && jugador_q == JUGADOR_REMOTO);
  assign timeout     = timeout_q;
  assign ack_out     = ack_q;
  assign err_frame   = err_q;

endmodule

// File: tb/tb_turno_jugada_ctrl.sv
// Self-checking bench for turno_jugada_ctrl: directed scenarios plus a random
// sequence of moves, bad frames and idle turns against a turn-level model.
module tb_turno_jugada_ctrl;

  localparam int MAX_J = 6;
  localparam int SYNC  = 2;
  localparam int TURN  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       btn_valid = 1'b0;
  logic [2:0] btn_jugada = 3'd0;
  logic       move_ready = 1'b0;
  logic       game_over = 1'b0;
  logic       move_valid;
  logic [2:0] jugada_out;
  logic       jugador_out;
  logic       turno;
  logic       timeout;
  logic       ack_out;
  logic       err_frame;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int tout_cnt = 0;
  int mv_cnt = 0;

  // Turn-level model of what the controller should be doing.
  int m_turn = 0;
  int m_err = 0;
  int m_ack = 0;
  int m_tout = 0;
  int entry_cyc = 0;

  turno_jugada_ctrl #(
    .CLK_HZ(100), .TURN_TIMEOUT_S(1), .MAX_JUGADA(MAX_J), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .btn_valid(btn_valid), .btn_jugada(btn_jugada), .move_ready(move_ready),
    .game_over(game_over), .move_valid(move_valid), .jugada_out(jugada_out),
    .jugador_out(jugador_out), .turno(turno), .timeout(timeout),
    .ack_out(ack_out), .err_frame(err_frame)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (timeout) tout_cnt++;
    if (move_valid) mv_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mv"}, move_valid, 0);
    check({tag, "_jugada"}, jugada_out, 0);
    check({tag, "_jugador"}, jugador_out, 0);
    check({tag, "_turno"}, turno, 0);
    check({tag, "_tout"}, timeout, 0);
    check({tag, "_ack"}, ack_out, 0);
    check({tag, "_err"}, err_frame, 0);
  endtask

  // Tasks start and end just after a rising edge.
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; btn_valid = 1'b0; move_ready = 1'b0; game_over = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); check_zero("rst");
    @(posedge clk); #1 rst = 1'b0;
    entry_cyc = cyc;
    m_turn = 0; m_err = 0; m_ack = 0;
  endtask

  task automatic send_btn(input int j);
    btn_valid = 1'b1; btn_jugada = 3'(j);
    @(posedge clk); #1 btn_valid = 1'b0; btn_jugada = 3'($urandom);
  endtask

  task automatic accept_move(input int exp_j, input int exp_p, input int hold);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check("mv_high", move_valid, 1);
    check("jugada", jugada_out, exp_j);
    check("jugador", jugador_out, exp_p);
    check("turno_issue", turno, exp_p);
    check("ack", ack_out, m_ack);
    check("err", err_frame, m_err);
    move_ready = 1'b1;
    @(posedge clk); #1 move_ready = 1'b0;
    entry_cyc = cyc;
    m_turn = 1 - exp_p;
    @(negedge clk);
    check("mv_low", move_valid, 0);
    check("turno_next", turno, m_turn);
    @(posedge clk); #1;
  endtask

  task automatic ignored_btn(input int j);
    send_btn(j);
    @(negedge clk);
    check("btn_ign_mv", move_valid, 0);
    check("btn_ign_turno", turno, m_turn);
    @(posedge clk); #1;
  endtask

  task automatic spi_bit(input logic b, input int ph);
    mosi = b;
    repeat (ph) @(posedge clk); #1 sck = 1'b1;
    repeat (ph) @(posedge clk); #1 sck = 1'b0;
  endtask

  // Final bit; lat = negedges after the pin edge until move_valid, or -1.
  task automatic spi_last(input logic b, input int ph, output int lat);
    mosi = b;
    repeat (ph) @(posedge clk); #1 sck = 1'b1;
    lat = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (move_valid && lat < 0) lat = k;
    end
    @(posedge clk); #1 sck = 1'b0;
  endtask

  task automatic spi_frame(input logic [7:0] b, input int ph, output int lat);
    ss_n = 1'b0;
    for (int i = 7; i >= 1; i--) spi_bit(b[i], ph);
    spi_last(b[0], ph, lat);
    ss_n = 1'b1; mosi = 1'b0;
    repeat (3) @(posedge clk); #1;
  endtask

  task automatic idle_turn();
    int mvb = mv_cnt;
    int n = 0;
    while (!timeout && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("tout_seen", timeout, 1);
    check("tout_cycle", cyc, entry_cyc + TURN);
    check("tout_no_mv", mv_cnt, mvb);
    m_turn = 1 - m_turn;
    m_tout++;
    entry_cyc = cyc;
    check("tout_turno", turno, m_turn);
    @(negedge clk);
    check("tout_pulse_len", timeout, 0);
    @(posedge clk); #1;
  endtask

  task automatic remote_frame(input logic [7:0] b, input int ph);
    int lat;
    logic good;
    good = (b[7:5] == 3'b101) && (int'(b[2:0]) <= MAX_J);
    spi_frame(b, ph, lat);
    if (m_turn == 1 && good) begin
      check("spi_lat_ok", (lat >= 1 && lat <= SYNC + 3), 1);
      m_ack = 1 - m_ack;
      accept_move(int'(b[2:0]), 1, $urandom_range(0, 3));
    end else begin
      m_err = 1;
      check("bad_frame_lat", lat, -1);
      check("bad_frame_err", err_frame, 1);
      check("bad_frame_turno", turno, m_turn);
      check("bad_frame_ack", ack_out, m_ack);
    end
  endtask

  task automatic go_remote();
    int j = $urandom_range(0, MAX_J);
    do_reset();
    send_btn(j);
    accept_move(j, 0, 0);
  endtask

  initial begin
    int lat;
    int j;
    logic [7:0] b;

    // Local move with ready already high.
    do_reset();
    move_ready = 1'b1;
    send_btn(3);
    @(negedge clk);
    check("t1_mv", move_valid, 1);
    check("t1_jugada", jugada_out, 3);
    check("t1_jugador", jugador_out, 0);
    @(posedge clk); #1 move_ready = 1'b0;
    @(negedge clk);
    check("t1_mv_low", move_valid, 0);
    check("t1_turno", turno, 1);
    @(posedge clk); #1;

    // Remote 8'hA5 at 10 clk per phase; the first seven bits land while the
    // local move waits in ISSUE so the turn timer cannot expire mid-frame.
    do_reset();
    b = 8'hA5;
    send_btn(3);
    ss_n = 1'b0;
    for (int i = 7; i >= 1; i--) spi_bit(b[i], 10);
    check("t2_no_early_err", err_frame, 0);
    accept_move(3, 0, 0);
    spi_last(b[0], 10, lat);
    ss_n = 1'b1;
    check("t2_lat_ok", (lat >= 1 && lat <= SYNC + 3), 1);
    m_ack = 1;
    accept_move(5, 1, 0);

    // Bad header, illegal index, and a partial frame discarded by ss_n.
    go_remote();
    remote_frame(8'h25, 3);
    go_remote();
    remote_frame(8'hA7, 3);
    go_remote();
    ss_n = 1'b0;
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom), 3);
    ss_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("t3_partial_mv", move_valid, 0);
    check("t3_partial_err", err_frame, 0);
    remote_frame(8'hA2, 3);

    // Idle local turn times out.
    do_reset();
    m_tout = tout_cnt;
    idle_turn();
    check("t4_tout_count", tout_cnt, m_tout);

    // Random sequence against the turn-level model.
    for (int it = 0; it < 40; it++) begin
      int act = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) do_reset();
      if (act == 0 || cyc - entry_cyc > 15) begin
        idle_turn();
      end else if (m_turn == 0) begin
        if (act <= 6) begin
          j = $urandom_range(0, 7);
          if (j <= MAX_J) begin
            send_btn(j);
            accept_move(j, 0, $urandom_range(0, 3));
          end else begin
            ignored_btn(j);
          end
        end else begin
          remote_frame(8'($urandom), $urandom_range(3, 4));
        end
      end else begin
        if (act <= 2) begin
          ignored_btn($urandom_range(0, 7));
        end else begin
          b = 8'($urandom);
          if ($urandom_range(0, 1) == 1) b[7:5] = 3'b101;
          remote_frame(b, $urandom_range(3, 4));
        end
      end
      check("rand_tout_count", tout_cnt, m_tout);
      check("rand_err", err_frame, m_err);
    end

    // game_over while a move is held in ISSUE: outputs stable, then DONE.
    do_reset();
    send_btn(4);
    game_over = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t5_hold_mv", move_valid, 1);
      check("t5_hold_jugada", jugada_out, 4);
      check("t5_hold_jugador", jugador_out, 0);
    end
    move_ready = 1'b1;
    @(posedge clk); #1 move_ready = 1'b0;
    @(negedge clk);
    check("t5_mv_low", move_valid, 0);
    check("t5_turno_done", turno, 0);
    @(posedge clk); #1;
    m_tout = tout_cnt;
    j = mv_cnt;
    send_btn(2);
    spi_frame(8'hA1, 3, lat);
    check("t5_spi_lat", lat, -1);
    check("t5_err", err_frame, 1);
    game_over = 1'b0;
    repeat (120) @(posedge clk); #1;
    send_btn(1);
    repeat (3) @(posedge clk); #1;
    check("t5_no_moves", mv_cnt, j);
    check("t5_no_tout", tout_cnt, m_tout);
    check("t5_turno", turno, 0);

    // rst during the 5th SPI bit, then a full frame in the local turn.
    go_remote();
    b = 8'hA5;
    ss_n = 1'b0;
    for (int i = 7; i >= 4; i--) spi_bit(b[i], 3);
    mosi = b[3];
    repeat (3) @(posedge clk); #1 sck = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("t6_spi_rst");
    sck = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    entry_cyc = cyc; m_turn = 0; m_err = 0; m_ack = 0;
    remote_frame(8'hA5, 3);

    // rst while a move is pending in ISSUE.
    do_reset();
    send_btn(6);
    @(negedge clk);
    check("t6_issue_mv", move_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_zero("t6_issue_rst");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("t6_move_lost", move_valid, 0);
    check("t6_turno", turno, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
